uart_core: RTL

//  Parametrised full-duplex UART: programmable divisor, 16x oversampled RX, configurable

---
 rtl/uart_core_pkg.sv | 40 ++++
 rtl/uart_fifo.sv | 56 +++++
 rtl/uart_core.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_core_pkg.sv
// Shared UART definitions: parity encodings, oversampling constants, FSM states
// and the sticky error record used by uart_core.
package uart_core_pkg;

  localparam logic [1:0] PAR_NONE     = 2'd0;
  localparam logic [1:0] PAR_NONE_ALT = 2'd1;
  localparam logic [1:0] PAR_EVEN     = 2'd2;
  localparam logic [1:0] PAR_ODD      = 2'd3;

  localparam int OVERSAMPLE = 16;
  localparam int MID        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  typedef struct packed {
    logic overrun;
    logic frame_err;
    logic parity_err;
  } uart_err_t;

  function automatic logic par_enabled(input logic [1:0] mode);
    case (mode)
      PAR_NONE, PAR_NONE_ALT: return 1'b0;
      PAR_EVEN, PAR_ODD:      return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Parity bit that makes data^parity come out 0 (even) or 1 (odd).
  function automatic logic par_calc(input logic [8:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered first-word-fall-through head.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = dout_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    // Head after this edge: bypass the write when it lands in the new head slot.
    dout_d = mem_q[rd_ptr_d[AW-1:0]];
    if (push_ok && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0]))
      dout_d = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: shared 16x tick generator, TX FSM fed from a FIFO,
// oversampled RX FSM feeding a FIFO, and sticky receive error flags.
module uart_core
  import uart_core_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              rxd,
  output logic              txd,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              err_clr,
  output logic              rx_overrun,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              tx_busy,
  output logic              irq
);

  localparam logic [4:0] OS_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] OS_LAST2 = 5'(2 * OVERSAMPLE - 1);
  localparam logic [3:0] RX_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] RX_MID   = 4'(MID - 1);
  localparam logic [3:0] BIT_LAST = 4'(DATA_W - 1);

  logic par_en;
  assign par_en = par_enabled(parity_mode);

  // Tick generator; the divisor is captured on wrap so changes land cleanly.
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_lim_q, div_lim_d;
  logic             tick;

  assign tick = (div_cnt_q == div_lim_q);

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    div_lim_d = div_lim_q;
    if (tick) begin
      div_cnt_d = '0;
      div_lim_d = baud_div;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      div_lim_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      div_lim_q <= div_lim_d;
    end
  end

  // RX synchroniser.
  logic [1:0] rxd_sync_q;
  logic       rxd_s;
  assign rxd_s = rxd_sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rxd_sync_q <= 2'b11;
    else      rxd_sync_q <= {rxd_sync_q[0], rxd};
  end

  // FIFOs
  logic              tx_full, tx_empty, tx_pop;
  logic [DATA_W-1:0] tx_head;
  logic              rx_full, rx_empty, rx_push, rx_pop_ok;

  assign tx_ready  = !tx_full;
  assign rx_valid  = !rx_empty;
  assign rx_pop_ok = rx_ready && rx_valid;

  uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid && tx_ready),
    .pop   (tx_pop),
    .din   (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .dout  (tx_head)
  );

  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;

  uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_ready),
    .din   (rx_shift_d),
    .full  (rx_full),
    .empty (rx_empty),
    .dout  (rx_data)
  );

  // TX FSM
  uart_state_e       tx_state_q, tx_state_d;
  logic [4:0]        tx_os_q, tx_os_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_par_q, tx_par_d;
  logic              txd_q, txd_d;
  logic [4:0]        tx_stop_last;

  assign tx_stop_last = stop2 ? OS_LAST2 : OS_LAST;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: if (tick && !tx_empty) begin
        tx_pop     = 1'b1;
        tx_state_d = ST_START;
        tx_os_d    = '0;
      end
      ST_START: if (tick) begin
        if (tx_os_q == OS_LAST) begin
          tx_state_d = ST_DATA;
          tx_os_d    = '0;
          tx_bit_d   = '0;
        end else tx_os_d = tx_os_q + 5'd1;
      end
      ST_DATA: if (tick) begin
        if (tx_os_q == OS_LAST) begin
          tx_os_d    = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == BIT_LAST) tx_state_d = par_en ? ST_PARITY : ST_STOP;
          else                      tx_bit_d   = tx_bit_q + 4'd1;
        end else tx_os_d = tx_os_q + 5'd1;
      end
      ST_PARITY: if (tick) begin
        if (tx_os_q == OS_LAST) begin
          tx_state_d = ST_STOP;
          tx_os_d    = '0;
        end else tx_os_d = tx_os_q + 5'd1;
      end
      ST_STOP: if (tick) begin
        // Chain straight into the next START when more data is queued.
        if (tx_os_q >= tx_stop_last) begin
          tx_os_d = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_state_d = ST_START;
          end else tx_state_d = ST_IDLE;
        end else tx_os_d = tx_os_q + 5'd1;
      end
      default: tx_state_d = ST_IDLE;
    endcase
    if (tx_pop) begin
      tx_shift_d = tx_head;
      tx_par_d   = par_calc(9'(tx_head), parity_mode);
    end
    case (tx_state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = tx_shift_d[0];
      ST_PARITY: txd_d = tx_par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= ST_IDLE;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (tx_state_q != ST_IDLE) || !tx_empty;

  // RX FSM
  uart_state_e rx_state_q, rx_state_d;
  logic [3:0]  rx_os_q, rx_os_d;
  logic [3:0]  rx_bit_q, rx_bit_d;
  logic        rx_par_q, rx_par_d;
  logic        frame_set, parity_set, overrun_set;
  uart_err_t   err_q, err_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    case (rx_state_q)
      ST_IDLE: if (tick && !rxd_s) begin
        rx_state_d = ST_START;
        rx_os_d    = '0;
      end
      ST_START: if (tick) begin
        // Half a bit in: a line that is high again was only a glitch.
        if (rx_os_q == RX_MID) begin
          rx_state_d = rxd_s ? ST_IDLE : ST_DATA;
          rx_os_d    = '0;
          rx_bit_d   = '0;
        end else rx_os_d = rx_os_q + 4'd1;
      end
      ST_DATA: if (tick) begin
        if (rx_os_q == RX_LAST) begin
          rx_os_d    = '0;
          rx_shift_d = {rxd_s, rx_shift_q[DATA_W-1:1]};
          if (rx_bit_q == BIT_LAST) rx_state_d = par_en ? ST_PARITY : ST_STOP;
          else                      rx_bit_d   = rx_bit_q + 4'd1;
        end else rx_os_d = rx_os_q + 4'd1;
      end
      ST_PARITY: if (tick) begin
        if (rx_os_q == RX_LAST) begin
          rx_par_d   = rxd_s;
          rx_os_d    = '0;
          rx_state_d = ST_STOP;
        end else rx_os_d = rx_os_q + 4'd1;
      end
      ST_STOP: if (tick) begin
        if (rx_os_q == RX_LAST) begin
          rx_push    = 1'b1;
          frame_set  = !rxd_s;
          parity_set = par_en && (par_calc(9'(rx_shift_q), parity_mode) != rx_par_q);
          rx_state_d = ST_IDLE;
        end else rx_os_d = rx_os_q + 4'd1;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  assign overrun_set = rx_push && rx_full && !rx_pop_ok;

  always_comb begin
    err_d.overrun    = overrun_set || (err_q.overrun    && !err_clr);
    err_d.frame_err  = frame_set   || (err_q.frame_err  && !err_clr);
    err_d.parity_err = parity_set  || (err_q.parity_err && !err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= ST_IDLE;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      err_q      <= err_d;
    end
  end

  assign rx_overrun    = err_q.overrun;
  assign rx_frame_err  = err_q.frame_err;
  assign rx_parity_err = err_q.parity_err;
  assign irq           = rx_valid || rx_overrun || rx_frame_err || rx_parity_err;

endmodule
